// File: rtl/cpu_pkg.sv
// Types and constants shared between the fetch unit and the control decoder.
package cpu_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic [6:0] {
    OP_LOAD   = 7'h03,
    OP_IMM    = 7'h13,
    OP_AUIPC  = 7'h17,
    OP_STORE  = 7'h23,
    OP_REG    = 7'h33,
    OP_LUI    = 7'h37,
    OP_BRANCH = 7'h63,
    OP_JALR   = 7'h67,
    OP_JAL    = 7'h6F
  } opcode_t;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    TRAP  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/pc_fetch_unit_next_pc_calc.sv
// Next-PC selection: JALR target beats JAL, which beats a taken branch, else PC+4.
module next_pc_calc #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] pc_i,
  input  logic [ADDR_WIDTH-1:0] imm_ext_i,
  input  logic [ADDR_WIDTH-1:0] alu_result_i,
  input  logic                  branch_i,
  input  logic                  jlink_i,
  input  logic                  pcsrcreg_i,
  input  logic                  zero_i,
  output logic [ADDR_WIDTH-1:0] next_pc_o,
  output logic [ADDR_WIDTH-1:0] pc_plus4_o,
  output logic                  misalign_o
);

  logic [ADDR_WIDTH-1:0] rel_target;

  assign pc_plus4_o = pc_i + ADDR_WIDTH'(4);
  assign rel_target = pc_i + imm_ext_i;

  // NOTE: the output gets a default first so no path through the mux can infer a latch.
  always_comb begin
    next_pc_o = pc_plus4_o;
    if (pcsrcreg_i) begin
      next_pc_o = {alu_result_i[ADDR_WIDTH-1:1], 1'b0};
    end else if (jlink_i || (branch_i && zero_i)) begin
      next_pc_o = rel_target;
    end
  end

  assign misalign_o = |next_pc_o[1:0];

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch stage: holds the PC, fetches one instruction at a time over req/ack and
// retires it into the next PC; a misaligned target parks the unit in TRAP.
module pc_fetch_unit
  import cpu_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    INSTR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = RESET_PC_DEFAULT
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   stall_i,
  input  logic                   branch_i,
  input  logic                   jlink_i,
  input  logic                   pcsrcreg_i,
  input  logic                   zero_i,
  input  logic [ADDR_WIDTH-1:0]  imm_ext_i,
  input  logic [ADDR_WIDTH-1:0]  alu_result_i,
  output logic                   imem_req_o,
  output logic [ADDR_WIDTH-1:0]  imem_addr_o,
  input  logic                   imem_ack_i,
  input  logic [INSTR_WIDTH-1:0] imem_rdata_i,
  output logic [INSTR_WIDTH-1:0] instr_o,
  output logic [6:0]             opcode_o,
  output logic                   instr_valid_o,
  output logic [ADDR_WIDTH-1:0]  pc_o,
  output logic [ADDR_WIDTH-1:0]  pc_plus4_o,
  output logic                   misaligned_o
);

  localparam logic [INSTR_WIDTH-1:0] NOP = INSTR_WIDTH'(NOP_INSTR);

  fetch_state_t           state_q;
  logic [ADDR_WIDTH-1:0]  pc_q;
  logic [INSTR_WIDTH-1:0] instr_q;
  logic                   valid_q;
  logic                   req_q;
  logic                   misaligned_q;

  logic [ADDR_WIDTH-1:0]  next_pc_d;
  logic                   misalign_d;

  next_pc_calc #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_next_pc (
    .pc_i         (pc_q),
    .imm_ext_i    (imm_ext_i),
    .alu_result_i (alu_result_i),
    .branch_i     (branch_i),
    .jlink_i      (jlink_i),
    .pcsrcreg_i   (pcsrcreg_i),
    .zero_i       (zero_i),
    .next_pc_o    (next_pc_d),
    .pc_plus4_o   (pc_plus4_o),
    .misalign_o   (misalign_d)
  );

  // The request is registered so it stays low through reset and rises on the
  // first edge after release; an ack only counts against a raised request.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      instr_q      <= NOP;
      valid_q      <= 1'b0;
      req_q        <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      case (state_q)
        FETCH: begin
          if (req_q && imem_ack_i) begin
            instr_q <= imem_rdata_i;
            valid_q <= 1'b1;
            req_q   <= 1'b0;
            state_q <= HOLD;
          end else begin
            req_q <= 1'b1;
          end
        end
        HOLD: begin
          if (!stall_i) begin
            instr_q <= NOP;
            valid_q <= 1'b0;
            if (misalign_d) begin
              misaligned_q <= 1'b1;
              state_q      <= TRAP;
            end else begin
              pc_q    <= next_pc_d;
              req_q   <= 1'b1;
              state_q <= FETCH;
            end
          end
        end
        TRAP: begin
          req_q <= 1'b0;
        end
        default: begin
          req_q   <= 1'b0;
          state_q <= TRAP;
        end
      endcase
    end
  end

  assign imem_req_o    = req_q;
  assign imem_addr_o   = pc_q;
  assign pc_o          = pc_q;
  assign instr_o       = instr_q;
  assign opcode_o      = instr_q[6:0];
  assign instr_valid_o = valid_q;
  assign misaligned_o  = misaligned_q;

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Fetch stage directly upstream of the control decoder.
- Holds the PC and fetches from instruction memory over a req/ack handshake.
- Presents the held instruction, and its opcode, to the decoder.
- On retire, consumes the decoder's Branch, Jlink and PCSrcReg outputs, plus the ALU zero flag and result, to compute the next PC.
- Multi-cycle: one instruction in flight; FETCH and HOLD states, plus a sticky TRAP state on misaligned targets.

Parameters:
- ADDR_WIDTH, 32, width of PC and instruction-memory address
- INSTR_WIDTH, 32, instruction width
- RESET_PC, 32'hBFC0_0000, PC loaded on reset

Ports:
- clk_i  input  1  clock, rising edge
- rst_n_i  input  1  asynchronous active-low reset
- stall_i  input  1  hold current instruction (downstream not ready)
- branch_i  input  1  Branch from decoder
- jlink_i  input  1  Jlink from decoder (JAL)
- pcsrcreg_i  input  1  PCSrcReg from decoder (JALR)
- zero_i  input  1  ALU branch condition true
- imm_ext_i  input  ADDR_WIDTH  sign-extended immediate
- alu_result_i  input  ADDR_WIDTH  rs1+imm (JALR target)
- imem_req_o  output  1  fetch request
- imem_addr_o  output  ADDR_WIDTH  fetch address (= pc_o)
- imem_ack_i  input  1  memory returns data this cycle
- imem_rdata_i  input  INSTR_WIDTH  fetched word
- instr_o  output  INSTR_WIDTH  held instruction
- opcode_o  output  7  instr_o[6:0], to decoder
- instr_valid_o  output  1  instr_o valid
- pc_o  output  ADDR_WIDTH  PC of held/in-flight instruction
- pc_plus4_o  output  ADDR_WIDTH  pc_o+4, for StorePC link writes
- misaligned_o  output  1  sticky fault flag

Behaviour:
- Reset (async, rst_n_i=0) sets:
  - state=FETCH, pc_o=RESET_PC
  - instr_o=32'h0000_0013 (NOP, addi x0,x0,0), instr_valid_o=0
  - misaligned_o=0, imem_req_o=0
- imem_req_o is forced 0 while reset is asserted. The first request is issued in the first cycle after deassertion.
- FETCH state:
  - imem_req_o=1, imem_addr_o=pc_o; the address stays stable until ack.
  - stall_i is ignored.
  - At the edge where imem_ack_i=1: instr_o<=imem_rdata_i, instr_valid_o<=1, go to HOLD.
- HOLD state:
  - imem_req_o=0.
  - If stall_i=1: hold everything.
  - If stall_i=0 (retire): pc_o<=next_pc, instr_valid_o<=0, instr_o<=NOP, go to FETCH.
- Minimum throughput: 2 cycles per instruction (ack in the first FETCH cycle).
- next_pc, priority high to low:
  - pcsrcreg_i: {alu_result_i[31:1],1'b0}
  - jlink_i: pc_o+imm_ext_i
  - branch_i & zero_i: pc_o+imm_ext_i
  - otherwise: pc_o+4
- All adds are modulo 2^ADDR_WIDTH. 32'hFFFF_FFFC+4 wraps to 0 with no flag.
- Misaligned target: if next_pc[1:0]!=0 at retire, go to TRAP:
  - misaligned_o=1, pc_o keeps the faulting instruction's PC
  - instr_o=NOP, instr_valid_o=0, no further requests
  - TRAP is left only by reset.
- imem_ack_i outside FETCH is ignored (no capture, no state change).
- Reset mid-fetch: the outstanding request is abandoned. A late ack arriving during reset is ignored; one arriving after reset completes the fresh FETCH at RESET_PC.
- pc_plus4_o and opcode_o are purely combinational from pc_o and instr_o.
- Control inputs are sampled only at the retire edge.

Decomposition:
- Shared package cpu_pkg holds:
  - the opcode enum shared with the decoder
  - RESET_PC default
  - NOP_INSTR constant
  - fetch_state_t enum {FETCH, HOLD, TRAP}
- One sub-module, next_pc_calc (combinational): computes the priority mux and adders, and outputs next_pc plus a misalign bit.

Test Plan:
- Reset release with ack one cycle later and rdata=32'h0050_0093:
  - FETCH addr is 32'hBFC0_0000.
  - instr_valid_o rises the next cycle with instr_o=32'h0050_0093 and opcode_o=7'h13.
  - Retire gives pc_o=32'hBFC0_0004.
- Branch at pc=32'h100, imm=-8:
  - branch_i=1, zero_i=1 -> next fetch addr 32'h0F8.
  - branch_i=1, zero_i=0 -> next fetch addr 32'h104.
- Priority check at pc=32'h200, imm=32'h40, alu_result_i=32'h0000_0301, pcsrcreg_i=1, jlink_i=1:
  - next addr is 32'h300 (bit0 cleared), pc_plus4_o=32'h204 while held.
- stall_i=1 for 5 cycles in HOLD:
  - instr_o and pc_o unchanged, imem_req_o=0.
  - Retire occurs on the first cycle with stall_i=0.
- Misaligned and wrap cases:
  - jlink_i=1, imm=32'h2 at pc=32'h100 -> misaligned_o=1, pc_o=32'h100, no further requests until reset.
  - pc=32'hFFFF_FFFC sequential -> next addr 32'h0.
- Reset asserted mid-FETCH with ack delayed 3 cycles:
  - During reset: outputs at reset values, imem_req_o=0.
  - After release: request at RESET_PC, and only the post-reset ack is captured.
